// File: rtl/mem_arbiter.sv
// Arbitrates the single-port unified memory between the CPU and a DMA/loader port.
// One transfer at a time; CPU has fixed priority, with a starvation guard for DMA.
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWData,
  output logic              CpuAck,
  output logic [DATA_W-1:0] CpuRData,
  output logic              CpuStall,
  input  logic              DmaReq,
  input  logic              DmaWe,
  input  logic [ADDR_W-1:0] DmaAddr,
  input  logic [DATA_W-1:0] DmaWData,
  output logic              DmaAck,
  output logic [DATA_W-1:0] DmaRData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemWe,
  input  logic [DATA_W-1:0] MemRData,
  output logic [2:0]        DbgState,
  output logic [3:0]        DbgStarveCnt
);

  // Handshake: a requester raises Req with We/Addr/WData and holds Req until
  // its Ack; Ack is a single-cycle pulse, RData is valid only while Ack=1 on a
  // read. Requests are sampled only in IDLE; a transfer always runs to its ack.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CPU_ACC = 3'd1,
    DMA_ACC = 3'd2,
    CPU_RD  = 3'd3,
    DMA_RD  = 3'd4
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state, state_next;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic [3:0]        starve_cnt;
  logic              grant_cpu, grant_dma;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state <= state_next;
      if (grant_cpu) begin
        lat_addr  <= CpuAddr;
        lat_wdata <= CpuWData;
        lat_we    <= CpuWe;
      end else if (grant_dma) begin
        lat_addr  <= DmaAddr;
        lat_wdata <= DmaWData;
        lat_we    <= DmaWe;
      end
      // Counts only CPU wins taken while DMA was also waiting.
      if (grant_dma)
        starve_cnt <= '0;
      else if (grant_cpu && DmaReq && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    state_next = state;
    grant_cpu  = 1'b0;
    grant_dma  = 1'b0;
    case (state)
      IDLE: begin
        if (CpuReq && (!DmaReq || starve_cnt != LIMIT)) begin
          grant_cpu  = 1'b1;
          state_next = CPU_ACC;
        end else if (DmaReq) begin
          grant_dma  = 1'b1;
          state_next = DMA_ACC;
        end
      end
      CPU_ACC: state_next = lat_we ? IDLE : CPU_RD;
      DMA_ACC: state_next = lat_we ? IDLE : DMA_RD;
      CPU_RD:  state_next = IDLE;
      DMA_RD:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from state and latches only, so an async reset
  // drops MemWe and both acks immediately.
  always_comb begin
    MemAddr  = lat_addr;
    MemWData = lat_wdata;
    MemWe    = 1'b0;
    CpuAck   = 1'b0;
    DmaAck   = 1'b0;
    CpuRData = '0;
    DmaRData = '0;
    case (state)
      CPU_ACC: begin
        MemWe  = lat_we;
        CpuAck = lat_we;
      end
      DMA_ACC: begin
        MemWe  = lat_we;
        DmaAck = lat_we;
      end
      CPU_RD: begin
        CpuAck   = 1'b1;
        CpuRData = MemRData;
      end
      DMA_RD: begin
        DmaAck   = 1'b1;
        DmaRData = MemRData;
      end
      default: ;
    endcase
  end

  assign CpuStall     = CpuReq & ~CpuAck;
  assign DbgState     = state;
  assign DbgStarveCnt = starve_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CPU_ACC = 3'd1;
  localparam logic [2:0] S_DMA_ACC = 3'd2;
  localparam logic [2:0] S_CPU_RD  = 3'd3;
  localparam logic [2:0] S_DMA_RD  = 3'd4;

  logic        CLK;
  logic        Reset_n;
  logic        CpuReq, CpuWe, DmaReq, DmaWe;
  logic [15:0] CpuAddr, CpuWData, DmaAddr, DmaWData;
  logic        CpuAck, DmaAck, CpuStall, MemWe;
  logic [15:0] CpuRData, DmaRData, MemAddr, MemWData, MemRData;
  logic [2:0]  DbgState;
  logic [3:0]  DbgStarveCnt;

  int n_checks;
  int n_fail;
  int wr_cnt;
  logic [15:0] mem [0:255];

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(3)) dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuAck(CpuAck), .CpuRData(CpuRData), .CpuStall(CpuStall),
    .DmaReq(DmaReq), .DmaWe(DmaWe), .DmaAddr(DmaAddr), .DmaWData(DmaWData),
    .DmaAck(DmaAck), .DmaRData(DmaRData),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemWe(MemWe), .MemRData(MemRData),
    .DbgState(DbgState), .DbgStarveCnt(DbgStarveCnt)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // synchronous single-port memory model
  always @(posedge CLK) begin
    if (MemWe) begin
      mem[MemAddr[7:0]] <= MemWData;
      wr_cnt <= wr_cnt + 1;
    end
    MemRData <= mem[MemAddr[7:0]];
  end

  // driver: one write through the arbiter, bounded wait for its ack
  task automatic do_write(input bit is_dma, input logic [15:0] a, input logic [15:0] d);
    bit got;
    got = 1'b0;
    if (is_dma) begin
      DmaWe = 1'b1; DmaAddr = a; DmaWData = d; DmaReq = 1'b1;
    end else begin
      CpuWe = 1'b1; CpuAddr = a; CpuWData = d; CpuReq = 1'b1;
    end
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge CLK);
      if ((is_dma && DmaAck) || (!is_dma && CpuAck)) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL do_write_timeout addr=%h: no ack within 8 cycles, ack required", a);
    end
    CpuReq = 1'b0; DmaReq = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    CpuReq = 0; CpuWe = 0; CpuAddr = 0; CpuWData = 0;
    DmaReq = 0; DmaWe = 0; DmaAddr = 0; DmaWData = 0;
    wr_cnt = 0;
    repeat (3) @(negedge CLK);
    Reset_n = 1'b1;
    n_checks++;
    if (DbgState !== S_IDLE || DbgStarveCnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d cnt=%0d, required 0/0", DbgState, DbgStarveCnt);
    end
    n_checks++;
    if ({MemWe, CpuAck, DmaAck, MemAddr, MemWData, CpuRData, DmaRData} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b cack=%b dack=%b addr=%h wd=%h crd=%h drd=%h, all 0 required",
               MemWe, CpuAck, DmaAck, MemAddr, MemWData, CpuRData, DmaRData);
    end
    // async assert in the middle of a CPU write
    CpuWe = 1'b1; CpuAddr = 16'h00AA; CpuWData = 16'h1111; CpuReq = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (MemWe !== 1'b1 || MemAddr !== 16'h00AA) begin
      n_fail++;
      $display("FAIL reset_pre_write: we=%b addr=%h, required 1/00aa", MemWe, MemAddr);
    end
    #2 Reset_n = 1'b0;
    #1;
    n_checks++;
    if (MemWe !== 1'b0 || CpuAck !== 1'b0 || DmaAck !== 1'b0 || MemAddr !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_async: we=%b cack=%b dack=%b addr=%h, all 0 required",
               MemWe, CpuAck, DmaAck, MemAddr);
    end
    CpuReq = 1'b0;
    @(negedge CLK);
    Reset_n = 1'b1;
    n_checks++;
    if (wr_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_no_write: writes=%0d, required 0", wr_cnt);
    end
  endtask

  task automatic test_cpu_write();
    int w0;
    w0 = wr_cnt;
    CpuWe = 1'b1; CpuAddr = 16'h0010; CpuWData = 16'hBEEF; CpuReq = 1'b1;
    #1;
    n_checks++;
    if (CpuStall !== 1'b1 || CpuAck !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_wr_c0: stall=%b ack=%b, required 1/0", CpuStall, CpuAck);
    end
    @(negedge CLK);
    n_checks++;
    if (MemWe !== 1'b1 || MemAddr !== 16'h0010 || MemWData !== 16'hBEEF || CpuAck !== 1'b1 || CpuStall !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_wr_c1: we=%b addr=%h wd=%h ack=%b stall=%b, required 1/0010/beef/1/0",
               MemWe, MemAddr, MemWData, CpuAck, CpuStall);
    end
    CpuReq = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (MemWe !== 1'b0 || CpuAck !== 1'b0 || wr_cnt - w0 !== 1 || mem[8'h10] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL cpu_wr_c2: we=%b ack=%b writes=%0d mem=%h, required 0/0/1/beef",
               MemWe, CpuAck, wr_cnt - w0, mem[8'h10]);
    end
  endtask

  task automatic test_dma_read();
    int w0;
    do_write(1'b1, 16'h0020, 16'h1234);
    w0 = wr_cnt;
    DmaWe = 1'b0; DmaAddr = 16'h0020; DmaReq = 1'b1;
    #1;
    n_checks++;
    if (DmaAck !== 1'b0 || DmaRData !== 16'h0 || MemWe !== 1'b0) begin
      n_fail++;
      $display("FAIL dma_rd_c0: ack=%b rd=%h we=%b, required 0/0000/0", DmaAck, DmaRData, MemWe);
    end
    @(negedge CLK);
    n_checks++;
    if (DbgState !== S_DMA_ACC || DmaAck !== 1'b0 || DmaRData !== 16'h0 || MemWe !== 1'b0 || MemAddr !== 16'h0020) begin
      n_fail++;
      $display("FAIL dma_rd_c1: st=%0d ack=%b rd=%h we=%b addr=%h, required 2/0/0000/0/0020",
               DbgState, DmaAck, DmaRData, MemWe, MemAddr);
    end
    @(negedge CLK);
    n_checks++;
    if (DbgState !== S_DMA_RD || DmaAck !== 1'b1 || DmaRData !== 16'h1234 || MemWe !== 1'b0) begin
      n_fail++;
      $display("FAIL dma_rd_c2: st=%0d ack=%b rd=%h we=%b, required 4/1/1234/0",
               DbgState, DmaAck, DmaRData, MemWe);
    end
    DmaReq = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (DmaAck !== 1'b0 || DmaRData !== 16'h0 || wr_cnt !== w0) begin
      n_fail++;
      $display("FAIL dma_rd_c3: ack=%b rd=%h writes=%0d, required 0/0000/0", DmaAck, DmaRData, wr_cnt - w0);
    end
  endtask

  task automatic test_contention();
    logic [2:0] exp_st;
    logic [3:0] exp_cnt;
    CpuWe = 1'b1; CpuAddr = 16'h0060; CpuWData = 16'hC0C0; CpuReq = 1'b1;
    DmaWe = 1'b1; DmaAddr = 16'h0070; DmaWData = 16'hD0D0; DmaReq = 1'b1;
    for (int r = 0; r < 8; r++) begin
      exp_st  = (r % 4 == 3) ? S_DMA_ACC : S_CPU_ACC;
      exp_cnt = (r % 4 == 3) ? 4'd0 : 4'((r % 4) + 1);
      @(negedge CLK);
      n_checks++;
      if (DbgState !== exp_st || DbgStarveCnt !== exp_cnt ||
          CpuAck !== (exp_st == S_CPU_ACC) || DmaAck !== (exp_st == S_DMA_ACC)) begin
        n_fail++;
        $display("FAIL contention_round%0d: st=%0d cnt=%0d cack=%b dack=%b, required st=%0d cnt=%0d",
                 r, DbgState, DbgStarveCnt, CpuAck, DmaAck, exp_st, exp_cnt);
      end
      @(negedge CLK);
    end
    CpuReq = 1'b0; DmaReq = 1'b0;
  endtask

  task automatic test_addr_change();
    do_write(1'b0, 16'h0030, 16'hAAAA);
    do_write(1'b0, 16'h0040, 16'h5555);
    CpuWe = 1'b0; CpuAddr = 16'h0030; CpuReq = 1'b1;
    @(negedge CLK);
    CpuAddr = 16'h0040;
    #1;
    n_checks++;
    if (DbgState !== S_CPU_ACC || MemAddr !== 16'h0030 || CpuStall !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_chg_c1: st=%0d addr=%h stall=%b, required 1/0030/1", DbgState, MemAddr, CpuStall);
    end
    @(negedge CLK);
    n_checks++;
    if (CpuAck !== 1'b1 || CpuRData !== 16'hAAAA || MemAddr !== 16'h0030) begin
      n_fail++;
      $display("FAIL addr_chg_c2: ack=%b rd=%h addr=%h, required 1/aaaa/0030", CpuAck, CpuRData, MemAddr);
    end
    CpuReq = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (CpuAck !== 1'b0 || CpuRData !== 16'h0 || DbgState !== S_IDLE) begin
      n_fail++;
      $display("FAIL addr_chg_c3: ack=%b rd=%h st=%0d, required 0/0000/0", CpuAck, CpuRData, DbgState);
    end
  endtask

  task automatic test_reset_mid_write();
    int w0;
    w0 = wr_cnt;
    DmaWe = 1'b1; DmaAddr = 16'h0050; DmaWData = 16'h7777; DmaReq = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (DbgState !== S_DMA_ACC || MemWe !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wr_pre: st=%0d we=%b, required 2/1", DbgState, MemWe);
    end
    #1 Reset_n = 1'b0;
    #1;
    n_checks++;
    if (MemWe !== 1'b0 || DmaAck !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wr_async: we=%b dack=%b, required 0/0", MemWe, DmaAck);
    end
    @(negedge CLK);
    Reset_n = 1'b1;
    n_checks++;
    if (DbgState !== S_IDLE || DmaAck !== 1'b0 || wr_cnt !== w0) begin
      n_fail++;
      $display("FAIL rst_wr_release: st=%0d dack=%b writes=%0d, required 0/0/0", DbgState, DmaAck, wr_cnt - w0);
    end
    @(negedge CLK);
    n_checks++;
    if (DmaAck !== 1'b1 || MemWe !== 1'b1 || MemAddr !== 16'h0050 || MemWData !== 16'h7777) begin
      n_fail++;
      $display("FAIL rst_wr_reissue: dack=%b we=%b addr=%h wd=%h, required 1/1/0050/7777",
               DmaAck, MemWe, MemAddr, MemWData);
    end
    DmaReq = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (wr_cnt - w0 !== 1 || mem[8'h50] !== 16'h7777 || DmaAck !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wr_done: writes=%0d mem=%h dack=%b, required 1/7777/0", wr_cnt - w0, mem[8'h50], DmaAck);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_cpu_write();
    test_dma_read();
    test_contention();
    test_addr_change();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not finish, finish required");
    $fatal(1);
  end

endmodule
